// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair: state encoding and default widths.
package lfsr_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CHECKING = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/lfsr_checker_if.sv
// Received word stream into the LFSR checker; a word is offered whenever in_valid is high (no backpressure).
interface lfsr_checker_if
  import lfsr_pkg::*;
#(
  parameter int N = DEF_N
);
  logic         in_valid;
  logic [N-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/lfsr_next.sv
// One LFSR step, shared with the generator so both ends stay bit-exact.
// Purely combinational; XNOR feedback over the tap mask shifted in at the MSB.
module lfsr_next #(
  parameter int N = 32
) (
  input  logic [N-1:0] cur_i,
  input  logic [N-1:0] poly_i,
  output logic [N-1:0] next_o
);
  logic fb;

  assign fb     = ~^(cur_i & poly_i);
  assign next_o = {fb, cur_i[N-1:1]};
endmodule

// File: rtl/lfsr_checker.sv
// Regenerates the LFSR sequence from seed/polynomial and checks the incoming stream word by word.
// Optional LFSR_CHECK_RESYNC_EN: on a CHECKING mismatch the expected sequence re-locks onto the received word.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [N-1:0]      seed_i,
  input  logic [N-1:0]      polynomial_i,
  lfsr_checker_if.slave     in_if,
  output logic [N-1:0]      expected_o,
  output logic              mismatch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  word_count_o,
  output logic [CNT_W-1:0]  error_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [N-1:0]     seed_q, seed_d;
  logic [N-1:0]     poly_q, poly_d;
  logic [N-1:0]     exp_q, exp_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic             mis_q, mis_d;

  logic [N-1:0]     step_nxt;
  logic [N-1:0]     chk_nxt;
  logic             is_bad;
  logic [CNT_W-1:0] wc_inc;
  logic [CNT_W-1:0] ec_inc;

  lfsr_next #(.N(N)) u_step (
    .cur_i  (exp_q),
    .poly_i (poly_q),
    .next_o (step_nxt)
  );

  assign is_bad = (in_if.in_data != exp_q);
  assign wc_inc = (wc_q == CNT_MAX) ? wc_q : wc_q + 1'b1;
  assign ec_inc = (ec_q == CNT_MAX) ? ec_q : ec_q + 1'b1;

`ifdef LFSR_CHECK_RESYNC_EN
  logic [N-1:0] resync_nxt;

  lfsr_next #(.N(N)) u_resync (
    .cur_i  (in_if.in_data),
    .poly_i (poly_q),
    .next_o (resync_nxt)
  );

  assign chk_nxt = is_bad ? resync_nxt : step_nxt;
`else
  assign chk_nxt = step_nxt;
`endif

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    poly_d  = poly_q;
    exp_d   = exp_q;
    wc_d    = wc_q;
    ec_d    = ec_q;
    mis_d   = 1'b0;

    if (clear_i) begin
      state_d = IDLE;
      exp_d   = '0;
      wc_d    = '0;
      ec_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = ARMED;
            seed_d  = seed_i;
            poly_d  = polynomial_i;
            exp_d   = seed_i;
            wc_d    = '0;
            ec_d    = '0;
          end
        end
        ARMED, CHECKING: begin
          if (in_if.in_valid) begin
            wc_d  = wc_inc;
            mis_d = is_bad;
            if (is_bad) ec_d = ec_inc;
            // Seed only closes the sequence once past the first word, so a lockup seed still takes two words.
            if (state_q == CHECKING && exp_q == seed_q) begin
              state_d = DONE;
            end else begin
              state_d = CHECKING;
              exp_d   = (state_q == CHECKING) ? chk_nxt : step_nxt;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      poly_q  <= '0;
      exp_q   <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      poly_q  <= poly_d;
      exp_q   <= exp_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
      mis_q   <= mis_d;
    end
  end

  assign expected_o    = exp_q;
  assign mismatch_o    = mis_q;
  assign busy_o        = (state_q == ARMED) || (state_q == CHECKING);
  assign done_o        = (state_q == DONE);
  assign word_count_o  = wc_q;
  assign error_count_o = ec_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the LFSR message generator: regenerates the expected LFSR word sequence from the same seed and polynomial, then compares it word-by-word against an incoming stream. Flags mismatches, counts words and errors, and detects the sequence closing back on its seed. Sits at the consumer end of the message path, for self-test and for bench loopback of the DES brute-force datapath.

## Interface
- N, 32, LFSR and data width
- CNT_W, 32, width of word and error counters
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  arm checker; samples seed and polynomial; honoured only in IDLE
- clear  in  1  abort and return to IDLE; zeroes counters
- seed  in  N  sequence start and stop word
- polynomial  in  N  tap mask
- in_valid  in  1  in_data holds a word this cycle
- in_data  in  N  received word
- expected  out  N  word expected next
- mismatch  out  1  one-cycle pulse, registered, one cycle after a mismatching accepted word
- busy  out  1  state is ARMED or CHECKING
- done  out  1  state is DONE
- word_count  out  CNT_W  accepted words, saturating
- error_count  out  CNT_W  mismatching words, saturating

## Operation
- LFSR step, bit-exact with the generator: fb = ~^(cur & poly_reg); next = {fb, cur[N-1:1]}.
- Registers: seed_reg, poly_reg, exp_reg, state, two counters, mismatch flop.
- States:
  - IDLE: start -> ARMED. Load seed_reg and poly_reg; set exp_reg = seed; clear counters.
  - ARMED: in_valid -> compare; word_count++; exp_reg = step(exp_reg); go to CHECKING.
  - CHECKING: in_valid -> compare; word_count++.
    - If exp_reg == seed_reg, this is the closing word: go to DONE; exp_reg holds.
    - Otherwise exp_reg = step(exp_reg).
  - DONE: in_valid ignored; hold until clear.
- A word is accepted only when in_valid is high in ARMED or CHECKING. Gaps in in_valid stall everything.
- Compare rule: in_data != exp_reg -> error_count++ (saturating), mismatch = 1 next cycle.
- A full closed sequence of period P is P+1 words: seed, …, seed.
- clear: any state -> IDLE. Counters zeroed, exp_reg = 0, mismatch = 0. A word presented in the same cycle is discarded.
- Priority: rst > clear > start/in_valid. start outside IDLE is ignored.
- Lockup seed (next == seed): closes after 2 words.
- Counters stop at 2^CNT_W-1; no wrap.

## Timing
- Reset: state IDLE. expected, word_count, error_count, seed_reg and poly_reg are 0. mismatch, busy and done are 0.
- start in cycle t -> busy=1 and expected=seed in cycle t+1.
- Accepted word in cycle t -> word_count, error_count, expected, mismatch and state all update at t+1.
- done rises the cycle after the closing word. busy falls the same cycle.
- One word can be accepted per cycle; no backpressure.

## Configuration
- LFSR_CHECK_RESYNC_EN defined: on a mismatch in CHECKING, exp_reg = step(in_data), so the checker re-locks to the stream. ARMED and the closing check are unchanged.
- Not defined: exp_reg always advances from its own value; mismatches never alter the expected sequence.

## Structure
- Shared package lfsr_pkg holds:
  - state encoding constants (IDLE, ARMED, CHECKING, DONE);
  - default N and CNT_W.
- Sub-module lfsr_next: combinational, parameter N; (cur, poly) -> next. Reused by the generator so both ends cannot diverge.
- Checker top contains the FSM, compare, counters and mismatch flop.

## Test plan
All scenarios use N=4, polynomial=4'h3. From seed 0 the expected sequence is 0,8,C,E,7,B,D,6,3,9,4,A,5,2,1,0.
- Clean run: start, seed=0; stream the 16 words back-to-back -> done one cycle after the last 0; word_count=16; error_count=0; mismatch never set.
- Gapped stream: same words with random 1–3 cycle in_valid gaps -> identical final counts; expected holds during gaps.
- Single corruption, macro off: 5th word 7 replaced by 0 -> one mismatch pulse; error_count=1; done after 16 words.
- Single corruption, macro on: same stimulus -> 0 and B both mismatch (error_count=2); D onward matches; done after 16 words.
- Lockup seed: seed=F; stream F,F -> done after word 2; word_count=2; error_count=0.
- Abort: clear after 5 words -> next cycle IDLE; busy=0; counters=0. A fresh start then completes the clean run; clear during the rst cycle has no effect.
